// File: rtl/matmul_acc_seq_if.sv
// Bus for matmul_acc_seq: start/busy/done handshake plus the flattened A, B and C matrices.
// Element (r,c) of each matrix sits at index r*MAT_SIZE+c.
interface matmul_acc_seq_if #(
   parameter int DAT_SIZE  = 8,
   parameter int MAT_SIZE  = 4,
   parameter int ACC_WIDTH = 2*DAT_SIZE + $clog2(MAT_SIZE)
);
   logic                 start;
   logic                 busy;
   logic                 done;
   logic [DAT_SIZE-1:0]  mat_a [MAT_SIZE*MAT_SIZE];
   logic [DAT_SIZE-1:0]  mat_b [MAT_SIZE*MAT_SIZE];
   logic [ACC_WIDTH-1:0] mat_c [MAT_SIZE*MAT_SIZE];

   modport master (output start, mat_a, mat_b, input busy, done, mat_c);
   modport slave  (input start, mat_a, mat_b, output busy, done, mat_c);
endinterface

// File: rtl/matmul_acc_seq.sv
// Sequential N x N matrix multiplier: one MAC per cycle, result C = A x B held in registers.
// Optional macro MATMUL_SIGNED_EN selects two's-complement operands; default build is unsigned.
//
// state | meaning
// IDLE  | waiting for start; last result held on mat_c
// RUN   | one MAC per cycle over i, j, k; C[i][j] written when k = N-1
// FIN   | done pulse for one cycle, then back to IDLE
module matmul_acc_seq #(
   parameter int DAT_SIZE  = 8,
   parameter int MAT_SIZE  = 4,
   parameter int ACC_WIDTH = 2*DAT_SIZE + $clog2(MAT_SIZE)
) (
   input logic             clk,
   input logic             rst_n,
   matmul_acc_seq_if.slave bus
);
   localparam int IDX_W = $clog2(MAT_SIZE);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(MAT_SIZE-1);

   typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

   state_t               state;
   logic [DAT_SIZE-1:0]  a_in [MAT_SIZE][MAT_SIZE];
   logic [DAT_SIZE-1:0]  b_in [MAT_SIZE][MAT_SIZE];
   logic [DAT_SIZE-1:0]  a_q  [MAT_SIZE][MAT_SIZE];
   logic [DAT_SIZE-1:0]  b_q  [MAT_SIZE][MAT_SIZE];
   logic [ACC_WIDTH-1:0] c_q  [MAT_SIZE][MAT_SIZE];
   logic [IDX_W-1:0]     i, j, k;
   logic [ACC_WIDTH-1:0] acc;
   logic [DAT_SIZE-1:0]  a_el, b_el;
   logic [ACC_WIDTH-1:0] a_ext, b_ext, prod, sum;
   logic                 busy_q, done_q;

   for (genvar r = 0; r < MAT_SIZE; r++) begin : g_row
      for (genvar c = 0; c < MAT_SIZE; c++) begin : g_col
         assign a_in[r][c]                = bus.mat_a[r*MAT_SIZE+c];
         assign b_in[r][c]                = bus.mat_b[r*MAT_SIZE+c];
         assign bus.mat_c[r*MAT_SIZE+c]   = c_q[r][c];
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;

   // Operands are extended to ACC_WIDTH before the multiply, so the product and sum never wrap.
   always_comb begin
      a_el = a_q[i][k];
      b_el = b_q[k][j];
`ifdef MATMUL_SIGNED_EN
      a_ext = {{(ACC_WIDTH-DAT_SIZE){a_el[DAT_SIZE-1]}}, a_el};
      b_ext = {{(ACC_WIDTH-DAT_SIZE){b_el[DAT_SIZE-1]}}, b_el};
`else
      a_ext = {{(ACC_WIDTH-DAT_SIZE){1'b0}}, a_el};
      b_ext = {{(ACC_WIDTH-DAT_SIZE){1'b0}}, b_el};
`endif
      prod = a_ext * b_ext;
      sum  = acc + prod;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= IDLE;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         i      <= '0;
         j      <= '0;
         k      <= '0;
         acc    <= '0;
         a_q    <= '{default: '0};
         b_q    <= '{default: '0};
         c_q    <= '{default: '0};
      end else begin
         case (state)
            IDLE: begin
               done_q <= 1'b0;
               if (bus.start) begin
                  a_q    <= a_in;
                  b_q    <= b_in;
                  i      <= '0;
                  j      <= '0;
                  k      <= '0;
                  acc    <= '0;
                  busy_q <= 1'b1;
                  state  <= RUN;
               end
            end
            RUN: begin
               if (k == IDX_LAST) begin
                  c_q[i][j] <= sum;
                  acc       <= '0;
                  k         <= '0;
                  if (j == IDX_LAST) begin
                     j <= '0;
                     if (i == IDX_LAST) begin
                        i      <= '0;
                        done_q <= 1'b1;
                        state  <= FIN;
                     end else begin
                        i <= i + 1'b1;
                     end
                  end else begin
                     j <= j + 1'b1;
                  end
               end else begin
                  acc <= sum;
                  k   <= k + 1'b1;
               end
            end
            FIN: begin
               done_q <= 1'b0;
               busy_q <= 1'b0;
               state  <= IDLE;
            end
            default: begin
               done_q <= 1'b0;
               busy_q <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_matmul_acc_seq.sv
// Scoreboard bench for matmul_acc_seq: a 2x2 and a 4x4 instance, directed operand sets.
module tb_matmul_acc_seq;
   localparam int D   = 8;
   localparam int AW2 = 2*D + 1;
   localparam int AW4 = 2*D + 2;

   typedef logic [0:3][D-1:0]    v4_t;
   typedef logic [0:15][D-1:0]   v16_t;
   typedef logic [0:3][AW2-1:0]  c4_t;
   typedef logic [0:15][AW4-1:0] c16_t;
   typedef struct { int per; c4_t c; }  exp2_t;
   typedef struct { int per; c16_t c; } exp4_t;

   logic clk = 1'b0;
   logic rst2_n = 1'b0;
   logic rst4_n = 1'b0;
   int   cyc = 0;
   int   passed = 0;
   int   total = 0;
   exp2_t q2[$];
   exp4_t q4[$];
   exp2_t m2;
   exp4_t m4;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   matmul_acc_seq_if #(.DAT_SIZE(D), .MAT_SIZE(2), .ACC_WIDTH(AW2)) if2 ();
   matmul_acc_seq_if #(.DAT_SIZE(D), .MAT_SIZE(4), .ACC_WIDTH(AW4)) if4 ();

   matmul_acc_seq #(.DAT_SIZE(D), .MAT_SIZE(2), .ACC_WIDTH(AW2)) dut2 (
      .clk(clk), .rst_n(rst2_n), .bus(if2.slave));
   matmul_acc_seq #(.DAT_SIZE(D), .MAT_SIZE(4), .ACC_WIDTH(AW4)) dut4 (
      .clk(clk), .rst_n(rst4_n), .bus(if4.slave));

   task automatic chk(input string name, input longint act, input longint req);
      total++;
      if (act == req) passed++;
      else $display("FAIL %s: actual %0d required %0d (cycle %0d)", name, act, req, cyc);
   endtask

   always @(negedge clk) begin
      if (if2.done) begin
         if (q2.size() == 0) chk("done2_unexpected", cyc, -1);
         else begin
            m2 = q2.pop_front();
            chk("done2_cycle", cyc, m2.per);
            for (int n = 0; n < 4; n++) chk("c2_elem", if2.mat_c[n], m2.c[n]);
         end
      end
   end

   always @(negedge clk) begin
      if (if4.done) begin
         if (q4.size() == 0) chk("done4_unexpected", cyc, -1);
         else begin
            m4 = q4.pop_front();
            chk("done4_cycle", cyc, m4.per);
            for (int n = 0; n < 16; n++) chk("c4_elem", if4.mat_c[n], m4.c[n]);
         end
      end
   end

   task automatic load2(input v4_t a, input v4_t b);
      for (int n = 0; n < 4; n++) begin
         if2.mat_a[n] = a[n];
         if2.mat_b[n] = b[n];
      end
   endtask

   task automatic push2(input int per, input c4_t c);
      exp2_t e;
      e.per = per;
      e.c   = c;
      q2.push_back(e);
   endtask

   task automatic drain2();
      int budget = 0;
      while ((q2.size() != 0 || if2.busy) && budget < 300) begin
         @(negedge clk);
         budget++;
      end
      chk("drain2_in_time", (budget < 300) ? 1 : 0, 1);
      repeat (3) @(negedge clk);
   endtask

   initial begin
      int   p;
      v16_t ident, bm;
      c16_t bc;
      exp4_t e4;

      if2.start = 1'b0;
      if4.start = 1'b0;
      load2(v4_t'{0, 0, 0, 0}, v4_t'{0, 0, 0, 0});
      for (int n = 0; n < 16; n++) begin
         if4.mat_a[n] = '0;
         if4.mat_b[n] = '0;
      end
      repeat (3) @(negedge clk);
      chk("rst_busy", if2.busy, 0);
      chk("rst_done", if2.done, 0);
      for (int n = 0; n < 4; n++) chk("rst_c", if2.mat_c[n], 0);
      rst2_n = 1'b1;
      rst4_n = 1'b1;
      @(negedge clk);

      // Basic 2x2 product with busy window check
      load2(v4_t'{1, 2, 3, 4}, v4_t'{5, 6, 7, 8});
      if2.start = 1'b1;
      p = cyc;
      push2(p + 9, c4_t'{19, 22, 43, 50});
      @(negedge clk);
      if2.start = 1'b0;
      for (int t = 1; t <= 9; t++) begin
         chk("t1_busy_high", if2.busy, 1);
         @(negedge clk);
      end
      chk("t1_busy_low", if2.busy, 0);
      drain2();

      // Full-scale operands
      load2(v4_t'{8'hFF, 8'hFF, 8'hFF, 8'hFF}, v4_t'{8'hFF, 8'hFF, 8'hFF, 8'hFF});
      if2.start = 1'b1;
      p = cyc;
`ifdef MATMUL_SIGNED_EN
      push2(p + 9, c4_t'{2, 2, 2, 2});
`else
      push2(p + 9, c4_t'{130050, 130050, 130050, 130050});
`endif
      @(negedge clk);
      if2.start = 1'b0;
      drain2();

      // Start re-pulsed mid-run and in FIN, operand change after capture
      load2(v4_t'{2, 0, 0, 3}, v4_t'{1, 2, 3, 4});
      if2.start = 1'b1;
      p = cyc;
      push2(p + 9, c4_t'{2, 4, 9, 12});
      @(negedge clk);
      if2.start = 1'b0;
      @(negedge clk);
      load2(v4_t'{9, 9, 9, 9}, v4_t'{1, 2, 3, 4});
      @(negedge clk);
      if2.start = 1'b1;
      @(negedge clk);
      if2.start = 1'b0;
      while (cyc < p + 9) @(negedge clk);
      if2.start = 1'b1;
      @(negedge clk);
      if2.start = 1'b0;
      repeat (15) @(negedge clk);
      drain2();

      // Reset in the middle of a run
      load2(v4_t'{1, 1, 1, 1}, v4_t'{1, 1, 1, 1});
      if2.start = 1'b1;
      p = cyc;
      @(negedge clk);
      if2.start = 1'b0;
      while (cyc < p + 5) @(negedge clk);
      rst2_n = 1'b0;
      @(negedge clk);
      rst2_n = 1'b1;
      chk("abort_busy", if2.busy, 0);
      chk("abort_done", if2.done, 0);
      for (int n = 0; n < 4; n++) chk("abort_c_zero", if2.mat_c[n], 0);
      repeat (12) @(negedge clk);
      load2(v4_t'{1, 2, 3, 4}, v4_t'{1, 0, 0, 1});
      if2.start = 1'b1;
      p = cyc;
      push2(p + 9, c4_t'{1, 2, 3, 4});
      @(negedge clk);
      if2.start = 1'b0;
      drain2();

      // Start held high for 30 cycles: three back-to-back runs
      load2(v4_t'{0, 1, 1, 0}, v4_t'{5, 6, 7, 8});
      if2.start = 1'b1;
      p = cyc;
      push2(p + 9,  c4_t'{7, 8, 5, 6});
      push2(p + 19, c4_t'{7, 8, 5, 6});
      push2(p + 29, c4_t'{7, 8, 5, 6});
      for (int t = 1; t <= 30; t++) begin
         @(negedge clk);
         if (t == 9)  chk("b2b_busy_fin", if2.busy, 1);
         if (t == 10) chk("b2b_idle_gap", if2.busy, 0);
         if (t == 11) chk("b2b_busy_rerun", if2.busy, 1);
      end
      if2.start = 1'b0;
      drain2();

      // 4x4: identity times B
      bm = v16_t'{3, 14, 15, 92, 65, 35, 89, 79, 32, 38, 46, 26, 43, 38, 32, 79};
      ident = '0;
      for (int n = 0; n < 16; n++) begin
         if ((n / 4) == (n % 4)) ident[n] = 8'd1;
         bc[n] = AW4'(bm[n]);
      end
      for (int n = 0; n < 16; n++) begin
         if4.mat_a[n] = ident[n];
         if4.mat_b[n] = bm[n];
      end
      if4.start = 1'b1;
      p = cyc;
      e4.per = p + 65;
      e4.c   = bc;
      q4.push_back(e4);
      @(negedge clk);
      if4.start = 1'b0;
      begin
         int budget = 0;
         while ((q4.size() != 0 || if4.busy) && budget < 300) begin
            @(negedge clk);
            budget++;
         end
         chk("drain4_in_time", (budget < 300) ? 1 : 0, 1);
      end
      repeat (3) @(negedge clk);

      chk("q2_empty", q2.size(), 0);
      chk("q4_empty", q4.size(), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
